// File: rtl/bitstream_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : bitstream_loader_if                                          |
// | Purpose   : Bundles the command, host word stream, readback stream and   |
// |             both scan-chain pin groups of bitstream_loader.              |
// | Modports  : slave  - the loader (drives in_ready, readback, status and   |
// |                      scan outputs; samples commands, words, returns)     |
// |             master - host/fabric side, directions reversed               |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
interface bitstream_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
);
  logic                  start;
  logic                  chain_sel;
  logic [LEN_WIDTH-1:0]  num_bits;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  busy;
  logic                  done;
  logic                  scan_clk;
  logic                  clb_scan_data;
  logic                  clb_scan_en;
  logic                  clb_scan_ret;
  logic                  conn_scan_data;
  logic                  conn_scan_en;
  logic                  conn_scan_ret;

  modport master (
    output start, chain_sel, num_bits, in_data, in_valid,
    output clb_scan_ret, conn_scan_ret,
    input  in_ready, out_data, out_valid, busy, done, scan_clk,
    input  clb_scan_data, clb_scan_en, conn_scan_data, conn_scan_en
  );

  modport slave (
    input  start, chain_sel, num_bits, in_data, in_valid,
    input  clb_scan_ret, conn_scan_ret,
    output in_ready, out_data, out_valid, busy, done, scan_clk,
    output clb_scan_data, clb_scan_en, conn_scan_data, conn_scan_en
  );
endinterface
`default_nettype wire

// File: rtl/bitstream_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : bitstream_loader                                             |
// | Purpose   : Serialises host configuration words LSB-first onto the CLB   |
// |             or connection scan chain with a clk/2 scan clock, while      |
// |             rebuilding readback words from the chain's return line.      |
// | Ports     : clk  - system clock                                          |
// |             rst  - asynchronous active-high reset                        |
// |             bus  - bitstream_loader_if.slave (command, word stream,      |
// |                    readback stream, status, scan pins)                   |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module bitstream_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input wire clk,
  input wire rst,
  bitstream_loader_if.slave bus
);

  localparam int c_POS_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                r_state, w_state_next;
  logic                  r_sel, w_sel_next;
  logic [LEN_WIDTH-1:0]  r_len, w_len_next;
  logic [LEN_WIDTH-1:0]  r_idx, w_idx_next;
  logic [c_POS_W-1:0]    r_pos, w_pos_next;     // bit position within the current word
  logic [DATA_WIDTH-1:0] r_sr, w_sr_next;
  logic [DATA_WIDTH-1:0] r_rb, w_rb_next;
  logic [DATA_WIDTH-1:0] r_out_data, w_out_data_next;
  logic                  w_out_valid_next;
  logic                  r_out_valid;
  logic                  r_in_ready, r_busy, r_done, r_scan_clk;
  logic                  r_clb_data, r_clb_en, r_conn_data, r_conn_en;
  logic                  w_ret, w_word_last, w_bit_last, w_active, w_data_next;

  assign w_word_last = (r_pos == c_POS_W'(DATA_WIDTH - 1));
  assign w_bit_last  = (r_idx == r_len - LEN_WIDTH'(1));
  assign w_ret       = r_sel ? bus.conn_scan_ret : bus.clb_scan_ret;

  always_comb begin
    w_state_next     = r_state;
    w_sel_next       = r_sel;
    w_len_next       = r_len;
    w_idx_next       = r_idx;
    w_pos_next       = r_pos;
    w_sr_next        = r_sr;
    w_rb_next        = r_rb;
    w_out_data_next  = r_out_data;
    w_out_valid_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_sel_next   = bus.chain_sel;
          w_len_next   = bus.num_bits;
          w_idx_next   = '0;
          w_pos_next   = '0;
          w_state_next = (bus.num_bits == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        // Start every word from zero so a partial final word reads back 0 above its last bit.
        w_rb_next = '0;
        if (bus.in_valid) begin
          w_sr_next    = bus.in_data;
          w_state_next = S_SHIFT_LO;
        end
      end
      S_SHIFT_LO: begin
        // Sampled just before scan_clk rises, so this is the old chain bit at r_idx.
        w_rb_next[r_pos] = w_ret;
        w_state_next     = S_SHIFT_HI;
        if (w_word_last || w_bit_last) begin
          w_out_valid_next = 1'b1;
          w_out_data_next  = w_rb_next;
        end
      end
      S_SHIFT_HI: begin
        w_sr_next  = r_sr >> 1;
        w_idx_next = r_idx + LEN_WIDTH'(1);
        w_pos_next = w_word_last ? '0 : r_pos + c_POS_W'(1);
        if (w_bit_last)       w_state_next = S_DONE;
        else if (w_word_last) w_state_next = S_LOAD;
        else                  w_state_next = S_SHIFT_LO;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    w_active    = (w_state_next == S_LOAD) || (w_state_next == S_SHIFT_LO) ||
                  (w_state_next == S_SHIFT_HI);
    w_data_next = ((w_state_next == S_SHIFT_LO) || (w_state_next == S_SHIFT_HI)) ?
                  w_sr_next[0] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_len       <= '0;
      r_idx       <= '0;
      r_pos       <= '0;
      r_sr        <= '0;
      r_rb        <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_scan_clk  <= 1'b0;
      r_clb_data  <= 1'b0;
      r_clb_en    <= 1'b0;
      r_conn_data <= 1'b0;
      r_conn_en   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_sel       <= w_sel_next;
      r_len       <= w_len_next;
      r_idx       <= w_idx_next;
      r_pos       <= w_pos_next;
      r_sr        <= w_sr_next;
      r_rb        <= w_rb_next;
      r_out_data  <= w_out_data_next;
      r_out_valid <= w_out_valid_next;
      r_in_ready  <= (w_state_next == S_LOAD);
      r_busy      <= w_active;
      r_done      <= (w_state_next == S_DONE);
      r_scan_clk  <= (w_state_next == S_SHIFT_HI);
      r_clb_en    <= w_active && !w_sel_next;
      r_conn_en   <= w_active && w_sel_next;
      r_clb_data  <= w_data_next && !w_sel_next;
      r_conn_data <= w_data_next && w_sel_next;
    end
  end

  assign bus.in_ready       = r_in_ready;
  assign bus.out_data       = r_out_data;
  assign bus.out_valid      = r_out_valid;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.scan_clk       = r_scan_clk;
  assign bus.clb_scan_data  = r_clb_data;
  assign bus.clb_scan_en    = r_clb_en;
  assign bus.conn_scan_data = r_conn_data;
  assign bus.conn_scan_en   = r_conn_en;

endmodule
`default_nettype wire

// File: tb/tb_bitstream_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_bitstream_loader                                          |
// | Purpose   : Self-checking bench for bitstream_loader. Behavioural scan   |
// |             chains (old contents followed by shifted-in bits) feed the   |
// |             return lines; expectations come from word/bit arithmetic.    |
// | Ports     : none                                                         |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_bitstream_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bitstream_loader_if #(.DATA_WIDTH(8), .LEN_WIDTH(16)) bif ();
  bitstream_loader #(.DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wire [16:0] w_outs = {bif.in_ready, bif.out_valid, bif.out_data, bif.busy, bif.done,
                        bif.scan_clk, bif.clb_scan_data, bif.clb_scan_en,
                        bif.conn_scan_data, bif.conn_scan_en};

  // Behavioural chains: return line shows old contents first, then the bits shifted in.
  int          clb_edges = 0, conn_edges = 0, stray_edges = 0;
  logic        clb_sh  [0:4095];
  logic        conn_sh [0:4095];
  logic [63:0] clb_old = '0, conn_old = '0;
  int          clb_base = 0, conn_base = 0;

  assign bif.clb_scan_ret  = clb_old[6'(clb_edges - clb_base)];
  assign bif.conn_scan_ret = conn_old[6'(conn_edges - conn_base)];

  always @(posedge bif.scan_clk) begin
    if (bif.clb_scan_en) begin
      clb_sh[clb_edges % 4096] = bif.clb_scan_data;
      clb_edges++;
    end
    if (bif.conn_scan_en) begin
      conn_sh[conn_edges % 4096] = bif.conn_scan_data;
      conn_edges++;
    end
    if (!bif.clb_scan_en && !bif.conn_scan_en) stray_edges++;
  end

  logic [7:0] rb_buf [0:1023];
  int         rb_cnt = 0;
  always @(negedge clk) begin
    if (bif.out_valid) begin
      rb_buf[rb_cnt % 1024] = bif.out_data;
      rb_cnt++;
    end
  end

  // Shared stimulus buffers and run results.
  logic [7:0] wbuf [0:15];
  int   r_T, r_done, r_viol;
  logic tr_clk [0:1023];
  logic tr_data[0:1023];
  logic tr_ready[0:1023];

  function automatic logic get_sh(input logic sel, input int idx);
    return sel ? conn_sh[idx % 4096] : clb_sh[idx % 4096];
  endfunction

  task automatic preload(input logic sel, input logic [63:0] v);
    if (sel) begin conn_old = v; conn_base = conn_edges; end
    else     begin clb_old  = v; clb_base  = clb_edges;  end
  endtask

  // Issues one load and collects timing, a per-cycle trace and invariant violations.
  task automatic run_load(input logic sel, input int n, input int stall);
    int wait_cnt, widx, k;
    bit hs;
    logic sel_en, oth_en, oth_data;
    r_viol = 0;
    r_done = -1;
    for (int i = 0; i < 1024; i++) begin tr_clk[i] = 0; tr_data[i] = 0; tr_ready[i] = 0; end
    @(negedge clk);
    bif.start = 1'b1; bif.chain_sel = sel; bif.num_bits = 16'(n);
    bif.in_data = wbuf[0]; bif.in_valid = 1'b1;
    r_T = cyc; widx = 0; wait_cnt = 0; hs = 0;
    for (int b = 0; b < 2000; b++) begin
      @(negedge clk);
      bif.start = 1'b0;
      if (hs) begin
        widx++;
        bif.in_data  = wbuf[widx % 16];
        bif.in_valid = (stall == 0);
        wait_cnt     = 0;
      end
      sel_en   = sel ? bif.conn_scan_en : bif.clb_scan_en;
      oth_en   = sel ? bif.clb_scan_en : bif.conn_scan_en;
      oth_data = sel ? bif.clb_scan_data : bif.conn_scan_data;
      k = cyc - r_T;
      if (k >= 0 && k < 1024) begin
        tr_clk[k]   = bif.scan_clk;
        tr_data[k]  = sel ? bif.conn_scan_data : bif.clb_scan_data;
        tr_ready[k] = bif.in_ready;
      end
      if (oth_en || oth_data) r_viol++;
      if (sel_en !== bif.busy) r_viol++;
      if (bif.in_ready && bif.scan_clk) r_viol++;
      if (bif.done) begin r_done = cyc; break; end
      if (bif.in_ready && !bif.in_valid) begin
        if (wait_cnt >= stall) bif.in_valid = 1'b1;
        wait_cnt++;
      end
      hs = bif.in_ready && bif.in_valid;
    end
    bif.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if (w_outs !== 17'd0) begin
      n_fail++; $display("FAIL reset_power_up: outputs=%h required 0", w_outs);
    end
    @(negedge clk); #2 rst = 1'b1; #1;
    n_tests++;
    if (w_outs !== 17'd0) begin
      n_fail++; $display("FAIL reset_idle: outputs=%h required 0", w_outs);
    end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bif.in_ready, bif.busy, bif.scan_clk} !== 3'b000) begin
      n_fail++; $display("FAIL reset_release: ready/busy/sclk=%b required 000",
                         {bif.in_ready, bif.busy, bif.scan_clk});
    end
  endtask

  task automatic test_conn_a5();
    logic [7:0] a5 = 8'hA5;
    logic [7:0] got;
    int base, rbb, bad;
    wbuf[0] = a5;
    preload(1'b1, {32'($urandom), 32'($urandom)});
    base = conn_edges; rbb = rb_cnt;
    run_load(1'b1, 8, 0);
    n_tests++;
    if (r_done !== r_T + 18) begin
      n_fail++; $display("FAIL a5_done: done at T+%0d required T+18", r_done - r_T);
    end
    n_tests++;
    if (conn_edges - base !== 8) begin
      n_fail++; $display("FAIL a5_edges: rises=%0d required 8", conn_edges - base);
    end
    for (int i = 0; i < 8; i++) got[i] = get_sh(1'b1, base + i);
    n_tests++;
    if (got !== a5) begin
      n_fail++; $display("FAIL a5_stream: shifted=%h required a5", got);
    end
    bad = 0;
    for (int k = 2; k <= 17; k++) begin
      if (tr_data[k] !== a5[(k - 2) / 2]) bad++;
      if (tr_clk[k] !== 1'(k % 2)) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL a5_waveform: bad cycles=%0d required 0", bad);
    end
    n_tests++;
    if (r_viol !== 0) begin
      n_fail++; $display("FAIL a5_other_chain: violations=%0d required 0", r_viol);
    end
    n_tests++;
    if (rb_buf[rbb % 1024] !== conn_old[7:0] || rb_cnt - rbb !== 1) begin
      n_fail++; $display("FAIL a5_readback: word=%h count=%0d required %h count 1",
                         rb_buf[rbb % 1024], rb_cnt - rbb, conn_old[7:0]);
    end
  endtask

  task automatic test_readback();
    logic [11:0] fin;
    int base, rbb;
    wbuf[0] = 8'hFF; wbuf[1] = 8'h0F;
    preload(1'b0, 64'h3C5);
    base = clb_edges; rbb = rb_cnt;
    run_load(1'b0, 12, 0);
    n_tests++;
    if (rb_cnt - rbb !== 2 || rb_buf[rbb % 1024] !== 8'hC5 || rb_buf[(rbb + 1) % 1024] !== 8'h03) begin
      n_fail++; $display("FAIL rb_words: count=%0d words=%h,%h required 2 c5,03", rb_cnt - rbb,
                         rb_buf[rbb % 1024], rb_buf[(rbb + 1) % 1024]);
    end
    for (int i = 0; i < 12; i++) fin[i] = get_sh(1'b0, base + i);
    n_tests++;
    if (fin !== 12'hFFF || clb_edges - base !== 12) begin
      n_fail++; $display("FAIL rb_chain: chain=%h rises=%0d required fff 12", fin, clb_edges - base);
    end
    n_tests++;
    if (r_done !== r_T + 27 || r_viol !== 0) begin
      n_fail++; $display("FAIL rb_timing: done T+%0d viol=%0d required T+27 0", r_done - r_T, r_viol);
    end
  endtask

  task automatic test_stall();
    logic s0 [0:19];
    int base, bad_m, bad_s, loads;
    for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
    preload(1'b1, {32'($urandom), 32'($urandom)});
    base = conn_edges;
    run_load(1'b1, 20, 0);
    for (int i = 0; i < 20; i++) s0[i] = get_sh(1'b1, base + i);
    preload(1'b1, conn_old);
    base = conn_edges;
    run_load(1'b1, 20, 5);
    bad_m = 0; bad_s = 0; loads = 0;
    for (int k = 0; k < 20; k++) begin
      if (get_sh(1'b1, base + k) !== wbuf[k / 8][k % 8]) bad_m++;
      if (get_sh(1'b1, base + k) !== s0[k]) bad_s++;
    end
    for (int k = 0; k < 1024; k++) if (tr_ready[k]) loads++;
    n_tests++;
    if (conn_edges - base !== 20 || bad_m !== 0) begin
      n_fail++; $display("FAIL stall_stream: rises=%0d bad=%0d required 20 0", conn_edges - base, bad_m);
    end
    n_tests++;
    if (bad_s !== 0) begin
      n_fail++; $display("FAIL stall_vs_nostall: differing bits=%0d required 0", bad_s);
    end
    n_tests++;
    if (r_done !== r_T + 1 + 3 + 40 + 10) begin
      n_fail++; $display("FAIL stall_done: done T+%0d required T+54", r_done - r_T);
    end
    n_tests++;
    if (loads !== 13 || r_viol !== 0) begin
      n_fail++; $display("FAIL stall_load: load cycles=%0d viol=%0d required 13 0", loads, r_viol);
    end
  endtask

  task automatic test_zero();
    int eb_c, eb_n, eb_s;
    eb_c = clb_edges; eb_n = conn_edges; eb_s = stray_edges;
    run_load(1'($urandom), 0, 0);
    n_tests++;
    if (r_done !== r_T + 1) begin
      n_fail++; $display("FAIL zero_done: done T+%0d required T+1", r_done - r_T);
    end
    @(negedge clk);
    n_tests++;
    if (tr_ready[1] !== 1'b0 || tr_clk[1] !== 1'b0 || r_viol !== 0 ||
        clb_edges + conn_edges + stray_edges !== eb_c + eb_n + eb_s) begin
      n_fail++; $display("FAIL zero_quiet: ready=%b sclk=%b viol=%0d extra rises=%0d required 0",
                         tr_ready[1], tr_clk[1], r_viol,
                         clb_edges + conn_edges + stray_edges - eb_c - eb_n - eb_s);
    end
  endtask

  task automatic test_random();
    logic sel;
    logic [7:0] exp_w;
    int n, stall, words, base, rbb, bad, exp_done;
    for (int it = 0; it < 6; it++) begin
      sel   = 1'($urandom);
      n     = $urandom_range(1, 40);
      stall = $urandom_range(0, 3);
      words = (n + 7) / 8;
      for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
      preload(sel, {32'($urandom), 32'($urandom)});
      base = sel ? conn_edges : clb_edges;
      rbb  = rb_cnt;
      run_load(sel, n, stall);
      exp_done = r_T + 1 + words + 2 * n + stall * (words - 1);
      n_tests++;
      if (r_done !== exp_done) begin
        n_fail++; $display("FAIL rand_done[%0d]: done T+%0d required T+%0d", it, r_done - r_T, exp_done - r_T);
      end
      bad = 0;
      for (int k = 0; k < n; k++) if (get_sh(sel, base + k) !== wbuf[k / 8][k % 8]) bad++;
      n_tests++;
      if (bad !== 0 || (sel ? conn_edges : clb_edges) - base !== n) begin
        n_fail++; $display("FAIL rand_stream[%0d]: bad=%0d rises=%0d required 0 %0d", it, bad,
                           (sel ? conn_edges : clb_edges) - base, n);
      end
      bad = 0;
      for (int j = 0; j < words; j++) begin
        exp_w = '0;
        for (int b = 0; b < 8; b++)
          if (8 * j + b < n) exp_w[b] = sel ? conn_old[8 * j + b] : clb_old[8 * j + b];
        if (rb_buf[(rbb + j) % 1024] !== exp_w) bad++;
      end
      n_tests++;
      if (bad !== 0 || rb_cnt - rbb !== words) begin
        n_fail++; $display("FAIL rand_readback[%0d]: bad words=%0d count=%0d required 0 %0d", it, bad,
                           rb_cnt - rbb, words);
      end
      n_tests++;
      if (r_viol !== 0) begin
        n_fail++; $display("FAIL rand_invariants[%0d]: violations=%0d required 0", it, r_viol);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base_c, base_n, bad;
    bit pulsed, reached, clb_seen;
    logic [7:0] got;
    for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
    preload(1'b1, {32'($urandom), 32'($urandom)});
    base_c = clb_edges; base_n = conn_edges;
    pulsed = 0; reached = 0; clb_seen = 0;
    @(negedge clk);
    bif.start = 1'b1; bif.chain_sel = 1'b1; bif.num_bits = 16'd16;
    bif.in_data = wbuf[0]; bif.in_valid = 1'b1;
    for (int b = 0; b < 200; b++) begin
      @(negedge clk);
      bif.start = 1'b0;
      if (bif.clb_scan_en || bif.clb_scan_data) clb_seen = 1;
      if (conn_edges - base_n >= 3) begin reached = 1; break; end
      if (conn_edges - base_n == 2 && !pulsed) begin
        bif.start = 1'b1; bif.chain_sel = 1'b0; bif.num_bits = 16'd5; pulsed = 1;
      end
    end
    n_tests++;
    if (!reached) begin
      n_fail++; $display("FAIL midrst_progress: rises=%0d required 3 within 200 cycles", conn_edges - base_n);
    end
    #2 rst = 1'b1; #1;
    n_tests++;
    if (w_outs !== 17'd0) begin
      n_fail++; $display("FAIL midrst_async: outputs=%h required 0", w_outs);
    end
    bif.in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (clb_seen || clb_edges !== base_c || conn_edges - base_n !== 3 || bif.busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ignored: clb_seen=%b clb rises=%0d conn rises=%0d busy=%b required 0 0 3 0",
                         clb_seen, clb_edges - base_c, conn_edges - base_n, bif.busy);
    end
    preload(1'b1, {32'($urandom), 32'($urandom)});
    base_n = conn_edges;
    run_load(1'b1, 8, 0);
    bad = 0;
    for (int i = 0; i < 8; i++) got[i] = get_sh(1'b1, base_n + i);
    n_tests++;
    if (r_done !== r_T + 18 || got !== wbuf[0] || r_viol !== 0) begin
      n_fail++; $display("FAIL midrst_reload: done T+%0d stream=%h viol=%0d required T+18 %h 0",
                         r_done - r_T, got, r_viol, wbuf[0]);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bif.start = 1'b0; bif.chain_sel = 1'b0; bif.num_bits = '0;
    bif.in_data = '0; bif.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_conn_a5();
    test_readback();
    test_stall();
    test_zero();
    test_random();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bitstream_loader.md
# bitstream_loader

Host-side driver for the fabric configuration scan chains. It accepts configuration words from a host over a valid/ready stream, serialises them LSB-first onto either the CLB chain or the connection chain, and generates the divided scan clock and scan enable for that chain. In parallel it samples the selected chain's return line and rebuilds readback words, so the old chain contents can be verified while the new bitstream is shifted in. It sits between the host/test controller and the fabric top level's `clb_scan_*`, `conn_scan_*` and `scan_clk` ports.

## Interface
- `DATA_WIDTH`, 8: width of host input and readback words.
- `LEN_WIDTH`, 16: width of the bit-count field.

Ports:
- `clk`  in  1  system clock. Single clock domain: one clock; reset is asynchronous and active-high.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle command strobe; honoured only in IDLE.
- `chain_sel`  in  1  0 = CLB chain, 1 = connection chain; latched on `start`.
- `num_bits`  in  LEN_WIDTH  chain length in bits; latched on `start`.
- `in_data`  in  DATA_WIDTH  configuration word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a word this cycle.
- `out_data`  out  DATA_WIDTH  readback word.
- `out_valid`  out  1  one-cycle readback strobe; there is no backpressure.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE.
- `done`  out  1  one-cycle completion pulse.
- `scan_clk`  out  1  generated scan clock; low when not shifting.
- `clb_scan_data`  out  1  serial data to the CLB chain input.
- `clb_scan_en`  out  1  CLB chain scan enable.
- `clb_scan_ret`  in  1  CLB chain serial output.
- `conn_scan_data`  out  1  serial data to the connection chain input.
- `conn_scan_en`  out  1  connection chain scan enable.
- `conn_scan_ret`  in  1  connection chain serial output.

## Operation
- Reset value: every output is 0 and the FSM is in IDLE. Reset takes effect immediately, including mid-shift.
- FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE. All outputs are registered.
- IDLE:
  - On `start` with `num_bits`=0, go to DONE.
  - On `start` otherwise, go to LOAD. The bit index is cleared.
- LOAD:
  - `in_ready`=1.
  - On `in_valid`, latch the word into the shift register and go to SHIFT_LO.
  - Otherwise stay in LOAD with `scan_clk` held low.
- SHIFT_LO:
  - `scan_clk`=0, and the selected `*_scan_data` = shift-register bit 0.
  - On the clk edge that leaves SHIFT_LO, sample the selected `*_scan_ret` into the readback register at position index mod DATA_WIDTH, then go to SHIFT_HI.
- SHIFT_HI:
  - `scan_clk`=1; the fabric shifts on this rising edge.
  - On exit: shift the register right and increment the index.
  - If index+1 == `num_bits`, go to DONE.
  - Else if (index+1) mod DATA_WIDTH == 0, go to LOAD.
  - Else go to SHIFT_LO.
- DONE: `done`=1 for one cycle, `busy` falls, then return to IDLE.
- Selected chain's `*_scan_en` = 1 in LOAD, SHIFT_LO and SHIFT_HI, including stalls. It is 0 in IDLE and DONE.
- Unselected chain: data = 0 and scan enable = 0 throughout.
- Readback word emission:
  - `out_valid` pulses in the SHIFT_HI cycle that follows sampling of a word's last bit. That is index mod DATA_WIDTH == DATA_WIDTH-1, or index == `num_bits`-1.
  - Bits of a partial final word above the last sampled bit are 0.
- Input words are consumed only as needed. A partial final word uses its low bits; its upper bits are ignored.
- `start` while not in IDLE is ignored.
- `num_bits` wraps nothing: maximum is 2^LEN_WIDTH-1 bits.

## Timing
- Accepted `start` at cycle T puts LOAD at T+1.
- Handshake at cycle L gives first SHIFT_LO at L+1.
- Each bit takes 2 clk cycles, so `scan_clk` = clk/2 while shifting.
- Data changes only while `scan_clk` is low, and is stable one full clk before each rising edge.
- Return bit k is the chain output before the k-th rising edge, i.e. the old bit k.
- Minimum cost per word: 1 LOAD cycle + 2·DATA_WIDTH cycles.
- With no stalls, N bits take N + ceil(N/DATA_WIDTH) + ... in general; DONE occurs at T + 1 + ceil(N/DATA_WIDTH) + 2N.
- `num_bits`=0: DONE at T+1 with no `scan_clk` edges.

## Test plan
- Reset: assert `rst` mid-idle → all outputs 0, `scan_clk` low; deassert → IDLE with `in_ready`=0.
- Connection chain, `num_bits`=8, word 0xA5 presented with `in_valid` high:
  - `start` at T → `conn_scan_data` = 1,0,1,0,0,1,0,1 across T+2..T+17, with exactly 8 `scan_clk` rises.
  - `done` at T+18.
  - `clb_scan_en` and `clb_scan_data` stay 0.
- Readback, CLB chain, 12-bit behavioural chain preloaded with 0x3C5, `num_bits`=12, words 0xFF then 0x0F:
  - `out_data` = 0xC5, then 0x03.
  - The chain finally holds 0xFFF.
- Stall: hold `in_valid` low 5 cycles between words → `scan_clk` stays low, `conn_scan_en` stays 1, no extra edges; the shifted stream is identical to the no-stall case.
- `num_bits`=0 → `done` at T+1; `in_ready` and `scan_clk` never rise.
- Assert `rst` after the 3rd `scan_clk` rise, with a second `start` pulsed mid-shift beforehand:
  - The mid-shift `start` is ignored.
  - Reset drives outputs to 0 in the same cycle.
  - A subsequent 8-bit load completes normally.
